// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU results and MEM/WB control, resolves
// conditional branches into a one-cycle PC redirect, and supports stall,
// flush and wrong-path kill after a taken branch.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic              ctl_regwrite,
  input  logic              ctl_memread,
  input  logic              ctl_memwrite,
  input  logic              ctl_memtoreg,
  input  logic              ctl_branch,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic [REG_AW-1:0] mem_wr_reg,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic              mem_carry,
  output logic              mem_zero,
  output logic              mem_pc_src,
  output logic              kill_upstream
);

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_out;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_branch_target;
  logic [REG_AW-1:0] r_wr_reg;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;
  logic              r_carry;
  logic              r_zero;
  logic              r_pc_src;

  logic              w_nxt_valid;
  logic [DATA_W-1:0] w_nxt_alu_out;
  logic [DATA_W-1:0] w_nxt_store_data;
  logic [DATA_W-1:0] w_nxt_branch_target;
  logic [REG_AW-1:0] w_nxt_wr_reg;
  logic              w_nxt_regwrite;
  logic              w_nxt_memread;
  logic              w_nxt_memwrite;
  logic              w_nxt_memtoreg;
  logic              w_nxt_carry;
  logic              w_nxt_zero;
  logic              w_nxt_pc_src;

  logic              w_kill;
  logic              w_taken;

  // While the redirect pulse is high the EX instruction is on the wrong path.
  assign w_kill  = r_pc_src;
  assign w_taken = in_valid & ctl_branch & alu_zero;

  // Next-state selection: kill > flush > stall (hold) > load.
  always_comb begin
    w_nxt_valid         = r_valid;
    w_nxt_alu_out       = r_alu_out;
    w_nxt_store_data    = r_store_data;
    w_nxt_branch_target = r_branch_target;
    w_nxt_wr_reg        = r_wr_reg;
    w_nxt_regwrite      = r_regwrite;
    w_nxt_memread       = r_memread;
    w_nxt_memwrite      = r_memwrite;
    w_nxt_memtoreg      = r_memtoreg;
    w_nxt_carry         = r_carry;
    w_nxt_zero          = r_zero;
    // Redirect never survives more than one edge, even on a hold.
    w_nxt_pc_src        = 1'b0;

    if (w_kill || flush) begin
      w_nxt_valid         = 1'b0;
      w_nxt_alu_out       = '0;
      w_nxt_store_data    = '0;
      w_nxt_branch_target = '0;
      w_nxt_wr_reg        = '0;
      w_nxt_regwrite      = 1'b0;
      w_nxt_memread       = 1'b0;
      w_nxt_memwrite      = 1'b0;
      w_nxt_memtoreg      = 1'b0;
      w_nxt_carry         = 1'b0;
      w_nxt_zero          = 1'b0;
    end else if (!stall) begin
      w_nxt_valid         = in_valid;
      w_nxt_alu_out       = alu_out;
      w_nxt_store_data    = store_data;
      w_nxt_branch_target = branch_target;
      w_nxt_wr_reg        = wr_reg;
      w_nxt_regwrite      = ctl_regwrite & in_valid;
      w_nxt_memread       = ctl_memread & in_valid;
      w_nxt_memwrite      = ctl_memwrite & in_valid;
      w_nxt_memtoreg      = ctl_memtoreg & in_valid;
      w_nxt_carry         = alu_carry;
      w_nxt_zero          = alu_zero;
      w_nxt_pc_src        = w_taken;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_alu_out       <= '0;
      r_store_data    <= '0;
      r_branch_target <= '0;
      r_wr_reg        <= '0;
      r_regwrite      <= 1'b0;
      r_memread       <= 1'b0;
      r_memwrite      <= 1'b0;
      r_memtoreg      <= 1'b0;
      r_carry         <= 1'b0;
      r_zero          <= 1'b0;
      r_pc_src        <= 1'b0;
    end else begin
      r_valid         <= w_nxt_valid;
      r_alu_out       <= w_nxt_alu_out;
      r_store_data    <= w_nxt_store_data;
      r_branch_target <= w_nxt_branch_target;
      r_wr_reg        <= w_nxt_wr_reg;
      r_regwrite      <= w_nxt_regwrite;
      r_memread       <= w_nxt_memread;
      r_memwrite      <= w_nxt_memwrite;
      r_memtoreg      <= w_nxt_memtoreg;
      r_carry         <= w_nxt_carry;
      r_zero          <= w_nxt_zero;
      r_pc_src        <= w_nxt_pc_src;
    end
  end

  assign mem_valid         = r_valid;
  assign mem_alu_out       = r_alu_out;
  assign mem_store_data    = r_store_data;
  assign mem_branch_target = r_branch_target;
  assign mem_wr_reg        = r_wr_reg;
  assign mem_regwrite      = r_regwrite;
  assign mem_memread       = r_memread;
  assign mem_memwrite      = r_memwrite;
  assign mem_memtoreg      = r_memtoreg;
  assign mem_carry         = r_carry;
  assign mem_zero          = r_zero;
  assign mem_pc_src        = r_pc_src;
  assign kill_upstream     = r_pc_src;

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the segmented processor; sits directly downstream of the 32-bit ALU.
- Captures ALU result, carry and zero flags, store data, destination register and MEM/WB control bits.
- Resolves conditional branches (branch & zero) and issues a one-shot PC redirect.
- Provides stall/hold and flush/bubble control, and kills the wrong-path instruction that follows a taken branch.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all stage contents this cycle.
- flush  input  1  insert a bubble this cycle (hazard unit).
- in_valid  input  1  EX stage holds a real instruction.
- alu_out  input  DATA_W  ALU result.
- alu_carry  input  1  ALU carry/borrow.
- alu_zero  input  1  ALU zero flag; meaningful only for SUB.
- branch_target  input  DATA_W  computed branch address.
- store_data  input  DATA_W  rt value for stores.
- wr_reg  input  REG_AW  destination register.
- ctl_regwrite, ctl_memread, ctl_memwrite, ctl_memtoreg, ctl_branch  input  1 each  decoded control.
- mem_valid  output  1  MEM stage holds a real instruction.
- mem_alu_out, mem_store_data, mem_branch_target  output  DATA_W  registered copies.
- mem_wr_reg  output  REG_AW  registered destination.
- mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg  output  1 each  registered control, forced 0 when mem_valid=0.
- mem_carry, mem_zero  output  1 each  registered ALU flags.
- mem_pc_src  output  1  one-cycle PC redirect pulse.
- kill_upstream  output  1  equals mem_pc_src; flushes IF/ID and ID/EX.

Behaviour:
- Reset: rst_n=0 asynchronously clears every output and internal state to 0 (mem_valid=0, mem_pc_src=0). Reset mid-stall or mid-branch discards everything; the first capture occurs on the first rising edge after release.
- Per-edge priority: reset > kill > flush > stall > load.
- kill: internal; asserted in the cycle mem_pc_src=1. The next edge loads a bubble regardless of stall or in_valid, because the EX instruction is wrong-path.
- Bubble: mem_valid=0; all control outputs 0; mem_wr_reg=0; data and flag registers cleared to 0.
- Stall (no kill/flush): all registers hold. mem_pc_src is forced to 0 on the hold edge, so a redirect is never repeated.
- Load: every mem_* register takes its input on the edge, giving 1-cycle latency. mem_valid is set to in_valid. Control bits are ANDed with in_valid.
- Branch resolution: taken = in_valid & ctl_branch & alu_zero, evaluated at load. mem_pc_src is registered as taken and is high for exactly one cycle.
  - If mem_pc_src=1 and stall=1 in the same cycle, kill wins: the next state is a bubble and mem_pc_src falls to 0.
- Flags: mem_carry and mem_zero are captured on every load. Consumers use mem_zero only with ctl_branch (SUB); for other ops the ALU zero value is don't-care.
- Width rules: no arithmetic here. All data paths are straight DATA_W registers with no truncation.
- Simultaneous flush and stall: flush wins and a bubble is inserted.
- flush with in_valid=0: bubble, identical result.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with all inputs 1 -> all outputs 0 immediately, without waiting for a clock edge. Release rst_n, then load alu_out=0x0000_0005, wr_reg=3, ctl_regwrite=1 -> next edge gives mem_alu_out=5, mem_wr_reg=3, mem_regwrite=1, mem_valid=1.
- Stall hold: load alu_out=0xDEAD_BEEF, then stall=1 for 3 cycles with alu_out=0x1234 -> mem_alu_out stays 0xDEAD_BEEF for all 3 cycles, then becomes 0x1234 on the first unstalled edge.
- Taken branch: ctl_branch=1, alu_zero=1, in_valid=1, branch_target=0x40 -> mem_pc_src=1 and kill_upstream=1 for exactly one cycle with mem_branch_target=0x40. The following instruction (ctl_regwrite=1) is captured as a bubble: mem_valid=0, mem_regwrite=0.
- Not taken: ctl_branch=1, alu_zero=0 -> mem_pc_src stays 0 and the next instruction loads normally.
- Taken branch with stall=1 during the pulse -> mem_pc_src is high for one cycle only, and the next state is a bubble.
- Flush vs stall: flush=1 and stall=1 together, with ctl_memwrite=1 valid in the stage -> next edge gives mem_valid=0 and mem_memwrite=0.
